// File: rtl/dec_secded_pipe.sv
// rtl/dec_secded_pipe.sv - two-stage SECDED decoder for (8,4), (16,11) and (32,26) codewords
// Statistics counters are built only when DEC_ERR_CNT_EN is defined.
module dec_secded_pipe #(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    work_mod,
    input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_INFO_WIDTH-1:0]     data_out,
    output logic [1:0]                    num_of_errors,
    input  logic                          cnt_clr,
    output logic [15:0]                   corr_cnt,
    output logic [15:0]                   uncorr_cnt
);
    localparam int W  = MAX_CODEWORD_WIDTH;
    localparam int SW = 5;
    localparam logic [1:0] ST_CLEAN   = 2'b00;
    localparam logic [1:0] ST_CORR    = 2'b01;
    localparam logic [1:0] ST_UNCORR  = 2'b10;
    localparam logic [1:0] ST_ILLEGAL = 2'b11;
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    function automatic int par_cnt(input logic [1:0] mode);
        case (mode)
            2'b00:   return 4;
            2'b01:   return 5;
            default: return 6;
        endcase
    endfunction

    // Info bit P+j carries the j-th non-power-of-two syndrome counting up from 3.
    function automatic logic [SW-1:0] col_val(input int p, input int i);
        int              cnt;
        logic [SW-1:0]   res;
        cnt = 0;
        res = '0;
        if (i < p - 1) return SW'(1 << i);
        if (i == p - 1) return '0;
        for (int v = 3; v < 32; v++) begin
            if ((v & (v - 1)) != 0) begin
                if (cnt == i - p) res = SW'(v);
                cnt++;
            end
        end
        return res;
    endfunction

    logic          s1_valid_q, s1_valid_d;
    logic [1:0]    s1_mode_q, s1_mode_d;
    logic [W-1:0]  s1_data_q, s1_data_d;
    logic [SW-1:0] s1_syn_q, s1_syn_d;
    logic          s1_par_q, s1_par_d;

    logic                      out_valid_q, out_valid_d;
    logic [MAX_INFO_WIDTH-1:0] data_out_q, data_out_d;
    logic [1:0]                num_of_errors_q, num_of_errors_d;

    logic          s1_adv, s2_adv;
    logic [W-1:0]  in_mask, in_cw;
    logic [SW-1:0] syn8, syn16, syn32;

    int                        p_cnt, lg, pos;
    logic [W-1:0]              fixed;
    logic [MAX_INFO_WIDTH-1:0] info;
    logic [1:0]                stat;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    always_comb begin
        syn8  = '0;
        syn16 = '0;
        syn32 = '0;
        for (int i = 0; i < W; i++) begin
            if (i < 8 && data_in[i])  syn8  = syn8 ^ col_val(4, i);
            if (i < 16 && data_in[i]) syn16 = syn16 ^ col_val(5, i);
            if (i < 32 && data_in[i]) syn32 = syn32 ^ col_val(6, i);
        end
        case (work_mod)
            2'b00:   in_mask = W'(8'hFF);
            2'b01:   in_mask = W'(16'hFFFF);
            2'b10:   in_mask = '1;
            default: in_mask = '0;
        endcase
        in_cw = data_in & in_mask;

        s1_valid_d = s1_valid_q;
        s1_mode_d  = s1_mode_q;
        s1_data_d  = s1_data_q;
        s1_syn_d   = s1_syn_q;
        s1_par_d   = s1_par_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_mode_d = work_mod;
                s1_data_d = in_cw;
                s1_par_d  = ^in_cw;
                case (work_mod)
                    2'b00:   s1_syn_d = syn8;
                    2'b01:   s1_syn_d = syn16;
                    2'b10:   s1_syn_d = syn32;
                    default: s1_syn_d = '0;
                endcase
            end
        end
    end

    always_comb begin
        p_cnt = par_cnt(s1_mode_q);
        lg    = 0;
        for (int b = 0; b < SW; b++) begin
            if (s1_syn_q[b]) lg = b;
        end
        // A power-of-two syndrome points at Hamming parity bit log2(s).
        if (s1_syn_q == '0) pos = p_cnt - 1;
        else if ((s1_syn_q & (s1_syn_q - SW'(1))) == '0) pos = lg;
        else pos = p_cnt - 2 + int'(s1_syn_q) - lg;

        fixed = s1_data_q;
        if (s1_par_q) fixed = s1_data_q ^ (ONE << pos);

        info = MAX_INFO_WIDTH'(fixed >> p_cnt);
        if (s1_mode_q == 2'b11) begin
            info = '0;
            stat = ST_ILLEGAL;
        end else if (s1_par_q) begin
            stat = ST_CORR;
        end else if (s1_syn_q != '0) begin
            stat = ST_UNCORR;
        end else begin
            stat = ST_CLEAN;
        end

        out_valid_d     = out_valid_q;
        data_out_d      = data_out_q;
        num_of_errors_d = num_of_errors_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                data_out_d      = info;
                num_of_errors_d = stat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q      <= 1'b0;
            s1_mode_q       <= '0;
            s1_data_q       <= '0;
            s1_syn_q        <= '0;
            s1_par_q        <= 1'b0;
            out_valid_q     <= 1'b0;
            data_out_q      <= '0;
            num_of_errors_q <= '0;
        end else begin
            s1_valid_q      <= s1_valid_d;
            s1_mode_q       <= s1_mode_d;
            s1_data_q       <= s1_data_d;
            s1_syn_q        <= s1_syn_d;
            s1_par_q        <= s1_par_d;
            out_valid_q     <= out_valid_d;
            data_out_q      <= data_out_d;
            num_of_errors_q <= num_of_errors_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign data_out      = data_out_q;
    assign num_of_errors = num_of_errors_q;

`ifdef DEC_ERR_CNT_EN
    logic [15:0] corr_cnt_q, corr_cnt_d;
    logic [15:0] uncorr_cnt_q, uncorr_cnt_d;
    logic        deliver;

    assign deliver = out_valid_q && out_ready;

    always_comb begin
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (cnt_clr) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else if (deliver) begin
            if (num_of_errors_q == ST_CORR && corr_cnt_q != 16'hFFFF)
                corr_cnt_d = corr_cnt_q + 16'd1;
            if (num_of_errors_q == ST_UNCORR && uncorr_cnt_q != 16'hFFFF)
                uncorr_cnt_d = uncorr_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign corr_cnt   = corr_cnt_q;
    assign uncorr_cnt = uncorr_cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign corr_cnt       = '0;
    assign uncorr_cnt     = '0;
`endif

endmodule

// File: tb/tb_dec_secded_pipe.sv
// tb/tb_dec_secded_pipe.sv - randomized self-checking bench for dec_secded_pipe
module tb_dec_secded_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  work_mod;
    logic [31:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] data_out;
    logic [1:0]  num_of_errors;
    logic        cnt_clr;
    logic [15:0] corr_cnt;
    logic [15:0] uncorr_cnt;

`ifdef DEC_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [25:0] q_d[$];
    logic [1:0]  q_s[$];
    logic [15:0] m_corr = 16'd0;
    logic [15:0] m_uncorr = 16'd0;

    bit          acc, dlv;
    logic [25:0] got_d, want_d;
    logic [1:0]  got_s, want_s;

    dec_secded_pipe dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .work_mod      (work_mod),
        .data_in       (data_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .data_out      (data_out),
        .num_of_errors (num_of_errors),
        .cnt_clr       (cnt_clr),
        .corr_cnt      (corr_cnt),
        .uncorr_cnt    (uncorr_cnt)
    );

    always #5 clk = ~clk;

    function automatic int pcnt(input logic [1:0] m);
        return (m == 2'b00) ? 4 : (m == 2'b01) ? 5 : 6;
    endfunction

    function automatic int ncnt(input logic [1:0] m);
        return (m == 2'b00) ? 8 : (m == 2'b01) ? 16 : 32;
    endfunction

    function automatic int colv(input logic [1:0] m, input int i);
        int p = pcnt(m);
        int n = ncnt(m);
        int v;
        if (i < p - 1) return 1 << i;
        if (i == p - 1) return 0;
        v = n;
        for (int b = n - 1; b >= i; b--) begin
            v--;
            while ((v & (v - 1)) == 0) v--;
        end
        return v;
    endfunction

    function automatic logic [31:0] encode(input logic [1:0] m, input logic [25:0] info);
        int          p = pcnt(m);
        int          n = ncnt(m);
        int          s;
        logic [31:0] cw;
        cw = 32'(info) << p;
        s  = 0;
        for (int i = p; i < n; i++) if (cw[i]) s = s ^ colv(m, i);
        for (int k = 0; k < p - 1; k++) cw[k] = s[k];
        cw[p-1] = ^cw;
        return cw;
    endfunction

    task automatic gen_word(output logic [1:0] m, output logic [31:0] d,
                            output logic [25:0] ed, output logic [1:0] es);
        int          p, n, k, e, a, b;
        logic [25:0] info;
        logic [31:0] cw, nmask;
        m = ($urandom_range(0, 9) == 9) ? 2'b11 : 2'($urandom_range(0, 2));
        if (m == 2'b11) begin
            d  = $urandom;
            ed = '0;
            es = 2'b11;
            return;
        end
        p     = pcnt(m);
        n     = ncnt(m);
        k     = n - p;
        info  = 26'($urandom) & 26'((64'd1 << k) - 1);
        cw    = encode(m, info);
        nmask = 32'((64'd1 << n) - 1);
        e     = int'($urandom_range(0, 2));
        ed    = info;
        es    = 2'(e);
        if (e == 1) begin
            a = int'($urandom_range(0, n - p + 2));
            a = (a < 2) ? a : p - 1 + (a - 2);
            cw[a] = ~cw[a];
        end else if (e == 2) begin
            a = int'($urandom_range(0, n - 1));
            b = (a + 1 + int'($urandom_range(0, n - 2))) % n;
            cw[a] = ~cw[a];
            cw[b] = ~cw[b];
            ed = 26'(cw >> p);
        end
        d = cw | ($urandom & ~nmask);
    endtask

    // Drives one cycle and keeps the reference queue and counter model in step.
    task automatic step(input bit v, input logic [1:0] m, input logic [31:0] d,
                        input logic [25:0] ed, input logic [1:0] es,
                        input bit ordy, input bit clr);
        @(negedge clk);
        in_valid  = v;
        work_mod  = m;
        data_in   = d;
        out_ready = ordy;
        cnt_clr   = clr;
        #1;
        acc    = v && in_ready;
        dlv    = out_valid && ordy;
        got_d  = data_out;
        got_s  = num_of_errors;
        want_d = 'x;
        want_s = 'x;
        if (dlv && q_d.size() > 0) begin
            want_d = q_d.pop_front();
            want_s = q_s.pop_front();
        end
        if (clr) begin
            m_corr   = 16'd0;
            m_uncorr = 16'd0;
        end else if (dlv) begin
            if (want_s === 2'b01 && m_corr != 16'hFFFF) m_corr++;
            if (want_s === 2'b10 && m_uncorr != 16'hFFFF) m_uncorr++;
        end
        if (acc) begin
            q_d.push_back(ed);
            q_s.push_back(es);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0; work_mod = 2'b00; data_in = '0; out_ready = 1'b0; cnt_clr = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (data_out !== 26'h0) begin n_bad++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
        n_cmp++; if (num_of_errors !== 2'b00) begin n_bad++; $display("FAIL reset_status: got %b expected 00", num_of_errors); end
        n_cmp++; if (corr_cnt !== 16'h0 || uncorr_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_counters: got %h/%h expected 0/0", corr_cnt, uncorr_cnt); end
        rst = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_vectors();
        logic [1:0]  vm[6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b11};
        logic [31:0] vi[6] = '{32'h000000B1, 32'h00000091, 32'h000000B9, 32'h00000030, 32'h80000000, 32'hDEADBEEF};
        logic [25:0] vd[6] = '{26'h00000B, 26'h00000B, 26'h00000B, 26'h000003, 26'h000000, 26'h000000};
        logic [1:0]  vs[6] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b11};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, vm[i], vi[i], vd[i], vs[i], 1'b1, 1'b0);
            n_cmp++; if (!acc) begin n_bad++; $display("FAIL vec%0d_accept: got %b expected 1", i, acc); end
            step(1'b0, 2'b00, '0, '0, '0, 1'b1, 1'b0);
            n_cmp++; if (dlv) begin n_bad++; $display("FAIL vec%0d_early: got out_valid %b expected 0", i, dlv); end
            step(1'b0, 2'b00, '0, '0, '0, 1'b1, 1'b0);
            n_cmp++;
            if (!dlv || got_d !== vd[i] || got_s !== vs[i]) begin
                n_bad++;
                $display("FAIL vec%0d: got v=%b d=%h s=%b expected v=1 d=%h s=%b", i, dlv, got_d, got_s, vd[i], vs[i]);
            end
        end
        step(1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0);
        n_cmp++;
        if (corr_cnt !== (CNT_EN ? 16'd3 : 16'd0) || uncorr_cnt !== (CNT_EN ? 16'd1 : 16'd0)) begin
            n_bad++;
            $display("FAIL vec_counters: got %0d/%0d expected %0d/%0d", corr_cnt, uncorr_cnt, CNT_EN ? 3 : 0, CNT_EN ? 1 : 0);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  m;
        logic [31:0] d;
        logic [25:0] ed;
        logic [1:0]  es;
        int          got = 0;
        int          stalls = 0;
        for (int i = 0; i < 43; i++) begin
            if (i < 40) gen_word(m, d, ed, es);
            step(i < 40, m, d, ed, es, 1'b1, 1'b0);
            if (i < 40 && !acc) stalls++;
            if (dlv) begin
                got++;
                n_cmp++;
                if (got_d !== want_d || got_s !== want_s) begin
                    n_bad++;
                    $display("FAIL b2b_word%0d: got d=%h s=%b expected d=%h s=%b", got, got_d, got_s, want_d, want_s);
                end
            end
        end
        n_cmp++; if (stalls != 0) begin n_bad++; $display("FAIL b2b_throughput: got %0d stalls expected 0", stalls); end
        n_cmp++; if (got != 40) begin n_bad++; $display("FAIL b2b_count: got %0d expected 40", got); end
    endtask

    task automatic test_backpressure();
        logic [1:0]  wm[3];
        logic [31:0] wd[3];
        logic [25:0] we[3];
        logic [1:0]  ws[3];
        int          idx = 0;
        int          got = 0;
        for (int i = 0; i < 3; i++) gen_word(wm[i], wd[i], we[i], ws[i]);
        for (int c = 0; c < 4; c++) begin
            step(idx < 3, wm[idx % 3], wd[idx % 3], we[idx % 3], ws[idx % 3], 1'b0, 1'b0);
            if (acc) idx++;
            if (c >= 2) begin
                n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready_c%0d: got %b expected 0", c, in_ready); end
                n_cmp++;
                if (out_valid !== 1'b1 || data_out !== q_d[0] || num_of_errors !== q_s[0]) begin
                    n_bad++;
                    $display("FAIL bp_hold_c%0d: got v=%b d=%h s=%b expected v=1 d=%h s=%b", c, out_valid, data_out, num_of_errors, q_d[0], q_s[0]);
                end
            end
        end
        n_cmp++; if (idx != 2) begin n_bad++; $display("FAIL bp_accepted: got %0d expected 2", idx); end
        for (int c = 0; c < 20 && got < 3; c++) begin
            step(idx < 3, wm[idx % 3], wd[idx % 3], we[idx % 3], ws[idx % 3], 1'b1, 1'b0);
            if (acc) idx++;
            if (dlv) begin
                n_cmp++;
                if (got_d !== we[got] || got_s !== ws[got]) begin
                    n_bad++;
                    $display("FAIL bp_order%0d: got d=%h s=%b expected d=%h s=%b", got, got_d, got_s, we[got], ws[got]);
                end
                got++;
            end
        end
        n_cmp++; if (got != 3) begin n_bad++; $display("FAIL bp_delivered: got %0d expected 3", got); end
    endtask

    task automatic test_random();
        logic [1:0]  m;
        logic [31:0] d;
        logic [25:0] ed;
        logic [1:0]  es;
        bit          have = 1'b0;
        int          sent = 0;
        int          got = 0;
        for (int c = 0; c < 4000 && got < 400; c++) begin
            if (!have && sent < 400 && $urandom_range(0, 3) != 0) begin
                gen_word(m, d, ed, es);
                have = 1'b1;
            end
            step(have, m, d, ed, es, $urandom_range(0, 3) != 0, 1'b0);
            if (acc) begin have = 1'b0; sent++; end
            if (dlv) begin
                got++;
                n_cmp++;
                if (got_d !== want_d || got_s !== want_s) begin
                    n_bad++;
                    $display("FAIL rand_word%0d: got d=%h s=%b expected d=%h s=%b", got, got_d, got_s, want_d, want_s);
                end
            end
        end
        n_cmp++; if (got != 400) begin n_bad++; $display("FAIL rand_count: got %0d expected 400", got); end
        step(1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0);
        n_cmp++;
        if (corr_cnt !== (CNT_EN ? m_corr : 16'd0) || uncorr_cnt !== (CNT_EN ? m_uncorr : 16'd0)) begin
            n_bad++;
            $display("FAIL rand_counters: got %0d/%0d expected %0d/%0d", corr_cnt, uncorr_cnt, CNT_EN ? m_corr : 16'd0, CNT_EN ? m_uncorr : 16'd0);
        end
    endtask

    task automatic test_cnt_clr();
        step(1'b1, 2'b00, 32'h00000091, 26'h00000B, 2'b01, 1'b0, 1'b0);
        step(1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0);
        step(1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0);
        step(1'b0, 2'b00, '0, '0, '0, 1'b1, 1'b1);
        n_cmp++; if (!dlv || got_s !== 2'b01) begin n_bad++; $display("FAIL clr_deliver: got v=%b s=%b expected v=1 s=01", dlv, got_s); end
        step(1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0);
        n_cmp++;
        if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL clr_wins: got %0d/%0d expected 0/0", corr_cnt, uncorr_cnt);
        end
        step(1'b1, 2'b00, 32'h000000B9, 26'h00000B, 2'b01, 1'b1, 1'b0);
        step(1'b0, 2'b00, '0, '0, '0, 1'b1, 1'b0);
        step(1'b0, 2'b00, '0, '0, '0, 1'b1, 1'b0);
        step(1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0);
        n_cmp++;
        if (corr_cnt !== (CNT_EN ? 16'd1 : 16'd0)) begin
            n_bad++;
            $display("FAIL clr_recount: got %0d expected %0d", corr_cnt, CNT_EN ? 1 : 0);
        end
    endtask

    task automatic test_reset_midflight();
        step(1'b1, 2'b01, encode(2'b01, 26'h155) ^ 32'h00000100, 26'h155, 2'b01, 1'b0, 1'b0);
        step(1'b1, 2'b00, 32'h00000091, 26'h00000B, 2'b01, 1'b0, 1'b0);
        step(1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_rst_counters: got %0d/%0d expected 0/0", corr_cnt, uncorr_cnt); end
        q_d.delete();
        q_s.delete();
        m_corr = 16'd0;
        m_uncorr = 16'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_release: got rdy=%b v=%b expected rdy=1 v=0", in_ready, out_valid); end
        step(1'b1, 2'b00, 32'h000000B1, 26'h00000B, 2'b00, 1'b1, 1'b0);
        step(1'b0, 2'b00, '0, '0, '0, 1'b1, 1'b0);
        n_cmp++; if (dlv) begin n_bad++; $display("FAIL mid_rst_early: got out_valid %b expected 0", dlv); end
        step(1'b0, 2'b00, '0, '0, '0, 1'b1, 1'b0);
        n_cmp++;
        if (!dlv || got_d !== 26'h00000B || got_s !== 2'b00) begin
            n_bad++;
            $display("FAIL mid_rst_first: got v=%b d=%h s=%b expected v=1 d=00000b s=00", dlv, got_d, got_s);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_cnt_clr();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
